corner_chain_tester: RTL

//  Sequencer/checker for the global-clock corner register chain (D-FF chain placed at the four
//  die corners, fed by one global clock). Flushes the chain, measures its latency with a single

---
 rtl/corner_chain_tester.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/corner_chain_tester.sv
// Sequencer/checker for the global-clock corner register chain: flush, probe latency,
// stream an LFSR pattern through the chain and count mismatches.
module corner_chain_tester #(
  parameter int unsigned MAX_LAT = 16,
  parameter int unsigned PAT_LEN = 64,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         chain_in,
  input  logic                         chain_out,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [$clog2(MAX_LAT+1)-1:0] lat_measured,
  output logic [7:0]                   err_count
);

  localparam int unsigned LW = $clog2(MAX_LAT + 1);
  localparam int unsigned IW = $clog2(MAX_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_PROBE, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  logic [LW-1:0]      cnt;
  logic [15:0]        lfsr;
  logic [15:0]        pat_cnt;
  logic [15:0]        cmp_cnt;
  logic [MAX_LAT-1:0] hist;
  logic [MAX_LAT-1:0] vhist;

  logic [IW-1:0] tap_c;
  logic          cmp_c;
  logic          mis_c;
  logic          last_cmp_c;
  logic          lfsr_fb_c;
  logic [7:0]    err_next_c;

  // hist[L-1] holds the chain_in value that should be leaving the chain this cycle
  assign tap_c      = IW'(lat_measured - LW'(1));
  assign cmp_c      = ((state == S_STREAM) || (state == S_DRAIN)) && vhist[tap_c];
  assign mis_c      = cmp_c && (chain_out != hist[tap_c]);
  assign err_next_c = (mis_c && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
  assign last_cmp_c = cmp_c && (cmp_cnt == 16'(PAT_LEN - 1));
  assign lfsr_fb_c  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      chain_in     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      lat_measured <= '0;
      err_count    <= '0;
      lfsr         <= SEED;
      cnt          <= '0;
      pat_cnt      <= '0;
      cmp_cnt      <= '0;
      hist         <= '0;
      vhist        <= '0;
    end else begin
      hist  <= {hist[MAX_LAT-2:0], chain_in};
      vhist <= {vhist[MAX_LAT-2:0], state == S_STREAM};
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_FLUSH;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            lat_measured <= '0;
            err_count    <= '0;
            lfsr         <= SEED;
            cnt          <= '0;
            pat_cnt      <= '0;
            cmp_cnt      <= '0;
            chain_in     <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (cnt == LW'(MAX_LAT - 1)) begin
            state    <= S_PROBE;
            chain_in <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        // cnt is 0 during the pulse cycle, so a hit at cnt==c means latency c
        S_PROBE: begin
          chain_in <= 1'b0;
          if ((cnt != '0) && chain_out) begin
            lat_measured <= cnt;
            state        <= S_STREAM;
            chain_in     <= lfsr[0];
            lfsr         <= {lfsr_fb_c, lfsr[15:1]};
            pat_cnt      <= 16'd1;
          end else if (cnt == LW'(MAX_LAT)) begin
            timeout <= 1'b1;
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        S_STREAM: begin
          err_count <= err_next_c;
          if (cmp_c) cmp_cnt <= cmp_cnt + 16'd1;
          if (pat_cnt == 16'(PAT_LEN)) begin
            state    <= S_DRAIN;
            chain_in <= 1'b0;
          end else begin
            chain_in <= lfsr[0];
            lfsr     <= {lfsr_fb_c, lfsr[15:1]};
            pat_cnt  <= pat_cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          err_count <= err_next_c;
          if (cmp_c) cmp_cnt <= cmp_cnt + 16'd1;
          if (last_cmp_c) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == 8'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
